// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control unit: opcodes, FSM states,
// ALU operation codes and status-register bit positions.
package sisc_pkg;

  // Instruction opcodes carried in IR[31:28]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_LOD = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_BRR = 4'h5;
  localparam logic [3:0] OP_BNE = 4'h6;
  localparam logic [3:0] OP_BNR = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation encodings; bit 0 enables the status-register update
  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_RR   = 4'b0001;
  localparam logic [3:0] ALU_RI   = 4'b0011;
  localparam logic [3:0] ALU_ADDI = 4'b0100;

  // Status register bit positions
  localparam int STAT_C = 3;
  localparam int STAT_V = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_START0,
    ST_START1,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  // ALU operation an instruction requests during EXECUTE
  function automatic logic [3:0] execAluOpFor(input logic [3:0] opcode, input logic immSel);
    logic [3:0] op;
    op = ALU_PASS;
    if (opcode == OP_ALU) begin
      op = immSel ? ALU_RI : ALU_RR;
    end else if (opcode == OP_LOD || opcode == OP_STR) begin
      op = ALU_ADDI;
    end
    return op;
  endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluation: decides whether the branch instruction in
// the IR is taken, given the condition mask and the status flags.
module sisc_br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       taken
);

  logic anyHit;

  // An empty mask on BRA/BRR means "branch always"; BNE/BNR take the
  // branch only when none of the selected flags is set.
  always_comb begin
    anyHit = |(mm & stat);
    taken  = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: taken = (mm == 4'b0000) | anyHit;
      OP_BNE, OP_BNR: taken = ~anyHit;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle control unit for the SISC processor. Steps each instruction
// through FETCH, DECODE, EXECUTE, MEM and WRITEBACK and drives the datapath
// enables as Moore outputs of the state and the IR opcode/mm fields.
module sisc_ctrl
  import sisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic [3:0] alu_op,
  output logic       ir_load,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       br_sel,
  output logic       pc_rst,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       dm_we,
  output logic       halt
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] execAluOp;
  logic       brTaken;

  sisc_br_cond u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (brTaken)
  );

  assign execAluOp = execAluOpFor(opcode, mm[0]);

  // State register; reset wins over everything, including HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_START0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed five-cycle instruction loop, HLT leaves it for good
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START0:    state_d = ST_START1;
      ST_START1:    state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_MEM;
      ST_MEM:       state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_START0;
    endcase
  end

  // Output decode; the ALU op bits above bit 0 stay put after EXECUTE so the
  // ALU result register keeps the same value, while the status update fires once
  always_comb begin
    alu_op   = ALU_PASS;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    halt     = 1'b0;
    case (state_q)
      ST_START0, ST_START1: begin
        pc_rst = 1'b1;
      end
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      ST_EXECUTE: begin
        alu_op = execAluOp;
        if (brTaken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (opcode == OP_BRR) || (opcode == OP_BNR);
        end
      end
      ST_MEM: begin
        alu_op = {execAluOp[3:1], 1'b0};
        dm_we  = (opcode == OP_STR);
      end
      ST_WRITEBACK: begin
        alu_op = {execAluOp[3:1], 1'b0};
        if (opcode == OP_ALU) begin
          rf_we = 1'b1;
        end else if (opcode == OP_LOD) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end
      ST_HALT: begin
        halt = 1'b1;
      end
      default: begin
        alu_op = ALU_PASS;
      end
    endcase
  end

endmodule
